sol_collector: RTL

Receives the move stream emitted by the cube solver core (`addr`, `step`, `q`), buffers up to 16 moves in order, and hands the finished solution to the PS side. The PS side reads it either as a packed 64-bit word or as a valid/ready move stream. The block sits between the solver's output port and the PS-facing register/stream interface, forming the read side of the solver's move-write interface.

---
 rtl/cube_pkg.sv | 15 +
 rtl/move_ram16x4.sv | 30 +++
 rtl/sol_collector.sv | 117 +++++++++++
 3 files changed

// File: rtl/cube_pkg.sv
// Shared move codes and collector state encoding
// for the cube solver output path.
package cube_pkg;

  localparam logic [3:0] MV_FIRST_TURN = 4'h0;
  localparam logic [3:0] MV_LAST_TURN  = 4'hE;
  localparam logic [3:0] MV_TERM       = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/move_ram16x4.sv
// 16x4 move register file: one write port, one
// combinational read port and a flat 64-bit view.
module move_ram16x4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [3:0]  wd,
  input  logic [3:0]  ra,
  output logic [3:0]  rd,
  output logic [63:0] flat
);

  logic [15:0][3:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd   = mem[ra];
  assign flat = mem;

endmodule

// File: rtl/sol_collector.sv
// Buffers the solver move stream and hands it to the
// PS side as a packed word and a valid/ready stream.
module sol_collector
  import cube_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [3:0] TERM  = MV_TERM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        q,
  input  logic [3:0]  addr,
  input  logic [3:0]  step,
  output logic [63:0] sol,
  output logic [4:0]  len,
  output logic        busy,
  output logic        err,
  output logic [3:0]  mv,
  output logic        mv_valid,
  input  logic        mv_ready,
  output logic        mv_last,
  output logic        done
);

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  state_e     state;
  logic [3:0] idx;
  logic [3:0] rp;
  logic [3:0] rd;
  logic       cap;
  logic       drain;
  logic       clr;
  logic       we;
  logic       is_term;

  assign cap     = (state == S_CAPTURE);
  assign drain   = (state == S_DRAIN);
  assign clr     = (state == S_IDLE) && run;
  assign is_term = (step == TERM);
  assign we      = cap && q && !is_term;

  move_ram16x4 u_ram (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .we   (we),
    .wa   (addr),
    .wd   (step),
    .ra   (rp),
    .rd   (rd),
    .flat (sol)
  );

  assign busy     = (state != S_IDLE);
  assign mv_valid = drain;
  assign mv       = drain ? rd : 4'h0;
  assign mv_last  = drain && ({1'b0, rp} == len - 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      rp    <= '0;
      len   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_CAPTURE;
            idx   <= '0;
            rp    <= '0;
            len   <= '0;
            err   <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (q) begin
            if (addr != idx) err <= 1'b1;
            if (!is_term) begin
              idx <= idx + 4'd1;
              len <= {1'b0, idx} + 5'd1;
              // a full buffer ends the solve without a terminator
              if (idx == LAST_IDX) begin
                state <= S_DRAIN;
                rp    <= '0;
              end
            end else if (len == 5'd0) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
              rp    <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (mv_ready) begin
            if (mv_last) begin
              state <= S_IDLE;
              rp    <= '0;
              done  <= 1'b1;
            end else begin
              rp <= rp + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
